// File: rtl/pmem_responder.sv
// Line-granular backing-store responder for the pmem_* handshake.
// One request in flight; each completes with a single-cycle pmem_resp after a fixed latency.
module pmem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int INDEX_BITS = 6,
  parameter int READ_LAT   = 4,
  parameter int WRITE_LAT  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_resp,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);
  localparam int OFFS  = 5;
  localparam int LINES = 1 << INDEX_BITS;
  localparam logic [7:0] RD_LD = 8'(READ_LAT - 1);
  localparam logic [7:0] WR_LD = 8'(WRITE_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic [INDEX_BITS-1:0] idx, addr_idx, rd_idx;
  logic [LINE_WIDTH-1:0] wbuf;
  logic                  is_wr;
  logic                  accept_wr, accept_rd, load_rd;
  logic [LINE_WIDTH-1:0] mem [LINES];
  logic                  unused_addr;

  assign addr_idx    = pmem_address[OFFS+INDEX_BITS-1:OFFS];
  assign unused_addr = ^{pmem_address[OFFS-1:0], pmem_address[ADDR_WIDTH-1:OFFS+INDEX_BITS]};
  assign pmem_resp   = (state == RESP);
  assign busy        = (state != IDLE);

  // cnt holds the wait cycles still to spend; a latency of 1 skips the wait state entirely
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    case (state)
      IDLE: begin
        if (pmem_write) begin
          accept_wr = 1'b1;
          cnt_nxt   = WR_LD;
          state_nxt = (WR_LD == 8'd0) ? RESP : WRITE_WAIT;
        end else if (pmem_read) begin
          accept_rd = 1'b1;
          cnt_nxt   = RD_LD;
          state_nxt = (RD_LD == 8'd0) ? RESP : READ_WAIT;
        end
      end
      READ_WAIT, WRITE_WAIT: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load_rd = (accept_rd && RD_LD == 8'd0) || (state == READ_WAIT && cnt == 8'd1);
  assign rd_idx  = (state == IDLE) ? addr_idx : idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      wbuf       <= '0;
      is_wr      <= 1'b0;
      pmem_rdata <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept_wr || accept_rd) begin
        idx   <= addr_idx;
        is_wr <= accept_wr;
      end
      if (accept_wr) wbuf <= pmem_wdata;
      if (load_rd) pmem_rdata <= mem[rd_idx];
      if (state == RESP) begin
        if (is_wr) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

  // Storage is deliberately unreset; the write lands on the edge that ends RESP
  always_ff @(posedge clk) begin
    if (state == RESP && is_wr) mem[idx] <= wbuf;
  end
endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Memory-side responder for the physical-memory line interface that the L2/prefetch cache controllers drive.
- Accepts pmem_read and pmem_write requests and returns a one-cycle pmem_resp after a programmable latency.
- Holds a line-granular backing store, so the cache hierarchy and prefetcher can be simulated and synthesised without an external memory model.
- Sits below the prefetch unit and L2 arbiter, at the far end of the pmem_* handshake.

Parameters:
- ADDR_WIDTH, 32, byte address width of pmem_address
- LINE_WIDTH, 256, line width in bits (32-byte lines; offset bits = 5)
- INDEX_BITS, 6, log2 of lines stored (64 lines)
- READ_LAT, 4, cycles from read acceptance to pmem_resp (1..255)
- WRITE_LAT, 6, cycles from write acceptance to pmem_resp (1..255)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- pmem_read  input  1  read request, held by initiator until pmem_resp
- pmem_write  input  1  write request, held by initiator until pmem_resp
- pmem_address  input  ADDR_WIDTH  line byte address, low 5 bits ignored
- pmem_wdata  input  LINE_WIDTH  write line data, valid while pmem_write high
- pmem_resp  output  1  one-cycle completion strobe
- pmem_rdata  output  LINE_WIDTH  read line data
- busy  output  1  high whenever state != IDLE
- rd_count  output  16  saturating count of completed reads
- wr_count  output  16  saturating count of completed writes

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; pmem_resp=0; pmem_rdata=0; busy=0; rd_count=0; wr_count=0; latency counter=0.
  - Backing array is not reset; its contents are undefined until first written.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RESP.
- IDLE:
  - pmem_write=1 at the edge: capture index=pmem_address[5+INDEX_BITS-1:5] and the wdata line, load counter=WRITE_LAT-1, go to WRITE_WAIT.
  - Else pmem_read=1: capture index, load counter=READ_LAT-1, go to READ_WAIT.
  - Write has priority when both are high; the read stays pending and is accepted after the write completes.
- READ_WAIT / WRITE_WAIT:
  - Counter decrements each cycle. When it is 0, go to RESP.
  - READ_WAIT→RESP edge loads pmem_rdata from array[index].
  - Request inputs are ignored while waiting; the captured index and wdata are used.
- RESP:
  - pmem_resp=1 for exactly this cycle, then go to IDLE.
  - Write: array[index] is written with the captured wdata on the edge ending RESP; wr_count increments.
  - Read: rd_count increments on the same edge.
  - Counters saturate at 16'hFFFF.
- Latency: a request first seen high in IDLE at cycle T gives pmem_resp high in cycle T+LAT.
  - Minimum LAT=1 means resp in the cycle after acceptance.
- pmem_rdata holds its value until the next read completes. Writes never change pmem_rdata.
- Back-to-back: the initiator drops its request on the cycle after resp. IDLE accepts a new request on the first edge after RESP.
  - If a request input is still high in that IDLE cycle, it is treated as a new request; the initiator must deassert.
- Read-after-write to the same line returns the new data, because the write commits before the next acceptance.
- Address wrap: only index bits are decoded; address bits above 5+INDEX_BITS are ignored (aliasing).
  - With default parameters, 0x0000_0040 and 0x0000_0840 map to the same line.
- Reset mid-operation: the FSM returns to IDLE immediately and pmem_resp drops. An uncommitted write is discarded and no counter increments.
- Requests deasserted before resp (protocol violation): the transaction still completes and resp is still issued.

Test Plan:
- Reset then idle: after reset, pmem_resp=0, busy=0, rd_count=wr_count=0, pmem_rdata=0 for 10 cycles with no requests.
- Write/read, default latencies:
  - write 0x0000_0020 with data {8{32'hDEADBEEF}}: resp exactly 6 cycles after acceptance.
  - read 0x0000_0020: resp 4 cycles after acceptance with pmem_rdata={8{32'hDEADBEEF}}; wr_count=1, rd_count=1.
- Simultaneous request: pmem_read=pmem_write=1 at 0x40, data=256'h1.
  - Write completes first (resp at +6).
  - Held read is then accepted and returns 256'h1 (resp at +4 after acceptance).
- Aliasing and offset: write 256'hA5 to 0x0000_0840, read 0x0000_005F → rdata=256'hA5.
- Reset mid-write: line 0x80 holds 256'h0. Start a write of 256'hFF to 0x80, assert reset in the 3rd wait cycle, release, read 0x80 → 256'h0; wr_count=0 after reset.
- READ_LAT=1 build: 100 back-to-back reads with the request dropped on the cycle after each resp. Each resp comes 1 cycle after acceptance; rd_count=100, with no lost or duplicate resp.
